instr_fetch_unit: RTL and testbench

- Front end of the 8-bit pipelined core, and the producer side of the control unit's opcode/ra interface.
- Reads instruction bytes from instruction memory into a small byte queue.
- Assembles one-byte and two-byte instructions. Opcode 4'd12 (LDM/LDD/STD) carries an immediate in the next byte.
- Presents complete instructions to the decode stage with a valid/ready handshake. Handles the reset-vector load and branch/interrupt redirects.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_byte_fifo.sv | 77 +++++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined core: opcode constants,
// instruction field positions and the fetch FSM state type.
package cpu_pkg;

   localparam int ADDR_W_DEF = 8;

   localparam logic [3:0] OP_NOP     = 4'd0;
   localparam logic [3:0] OP_LDM_GRP = 4'd12;

   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 4;

   typedef enum logic [1:0] {
      S_VEC_RD   = 2'd0,
      S_VEC_WAIT = 2'd1,
      S_RUN      = 2'd2
   } fetch_state_e;

   function automatic logic [3:0] instr_opcode(input logic [7:0] b);
      return b[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/fetch_byte_fifo.sv
// Byte queue between instruction memory and instruction assembly.
// Each entry holds a fetched byte and the address it was read from.
module fetch_byte_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [ADDR_W-1:0]        push_addr,
   input  logic [7:0]               push_data,
   input  logic                     pop1,
   input  logic                     pop2,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [ADDR_W-1:0]        head_addr,
   output logic [7:0]               head_data,
   output logic [7:0]               next_data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [PTR_W:0]    pop_n;
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [7:0]        data_mem [DEPTH];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pop_n    = pop2 ? (PTR_W+1)'(2) : (pop1 ? (PTR_W+1)'(1) : '0);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         rd_ptr_d = rd_ptr_q + pop_n[PTR_W-1:0];
         count_d  = count_q + {{PTR_W{1'b0}}, push} - pop_n;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; the occupancy count alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         addr_mem[wr_ptr_q] <= push_addr;
         data_mem[wr_ptr_q] <= push_data;
      end
   end

   assign occupancy = count_q;
   assign head_addr = addr_mem[rd_ptr_q];
   assign head_data = data_mem[rd_ptr_q];
   assign next_data = data_mem[rd_ptr_q + PTR_W'(1)];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: reset-vector load, byte prefetch, one/two-byte
// instruction assembly and branch/interrupt redirect handling.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int         ADDR_W         = ADDR_W_DEF,
   parameter int         DEPTH          = 4,
   parameter int         RESET_VEC_ADDR = 0,
   parameter logic [3:0] TWO_BYTE_OP    = OP_LDM_GRP
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [7:0]        instr,
   output logic [7:0]        imm,
   output logic              instr_two_byte,
   output logic [ADDR_W-1:0] instr_pc
);

   localparam int                OCC_W     = $clog2(DEPTH) + 1;
   localparam logic [OCC_W:0]    DEPTH_EXT = (OCC_W+1)'(DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
   logic              inflight_q, inflight_d;
   logic              drop_q, drop_d;

   logic              rd_en_c;
   logic [ADDR_W-1:0] addr_c;
   logic              push, pop1, pop2, flush;
   logic [OCC_W-1:0]  occupancy;
   logic [ADDR_W-1:0] head_addr;
   logic [7:0]        head_data, next_data;
   logic              head_two, valid_c, space_ok;

   fetch_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (ret_addr_q),
      .push_data (mem_rdata),
      .pop1      (pop1),
      .pop2      (pop2),
      .flush     (flush),
      .occupancy (occupancy),
      .head_addr (head_addr),
      .head_data (head_data),
      .next_data (next_data)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ret_addr_d = ret_addr_q;
      inflight_d = 1'b0;
      drop_d     = 1'b0;
      rd_en_c    = 1'b0;
      addr_c     = '0;
      push       = 1'b0;
      pop1       = 1'b0;
      pop2       = 1'b0;
      flush      = 1'b0;

      head_two = (instr_opcode(head_data) == TWO_BYTE_OP);
      valid_c  = (state_q == S_RUN) && (occupancy != '0) &&
                 (!head_two || (occupancy >= OCC_W'(2)));
      // Leave room for the byte already on its way back from memory.
      space_ok = ({1'b0, occupancy} + {{OCC_W{1'b0}}, inflight_q}) < DEPTH_EXT;

      case (state_q)
         S_VEC_RD: begin
            rd_en_c = 1'b1;
            addr_c  = ADDR_W'(RESET_VEC_ADDR);
            state_d = S_VEC_WAIT;
         end
         S_VEC_WAIT: begin
            pc_d    = ADDR_W'(mem_rdata);
            state_d = S_RUN;
         end
         S_RUN: begin
            addr_c = pc_q;
            if (redirect_valid) begin
               flush  = 1'b1;
               pc_d   = redirect_pc;
               drop_d = inflight_q;
            end else begin
               push = inflight_q && !drop_q;
               pop1 = valid_c && instr_ready && !head_two;
               pop2 = valid_c && instr_ready && head_two;
               if (space_ok) begin
                  rd_en_c    = 1'b1;
                  pc_d       = pc_q + ADDR_W'(1);
                  inflight_d = 1'b1;
                  ret_addr_d = pc_q;
               end
            end
         end
         default: state_d = S_VEC_RD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_VEC_RD;
         pc_q       <= '0;
         ret_addr_q <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ret_addr_q <= ret_addr_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // The vector read strobe is decoded from the reset state, so hold it off while in reset.
   assign mem_rd_en      = rd_en_c & rst;
   assign mem_addr       = rst ? addr_c : '0;
   assign instr_valid    = valid_c;
   assign instr          = valid_c ? head_data : 8'h00;
   assign instr_two_byte = valid_c & head_two;
   assign imm            = (valid_c && head_two) ? next_data : 8'h00;
   assign instr_pc       = valid_c ? head_addr : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model, reference instruction
// walker feeding a scoreboard, and directed phases for vector, stall, redirect, wrap, reset.
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mem_rd_en;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata = 8'h00;
   logic       redirect_valid = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       instr_valid;
   logic       instr_ready = 1'b1;
   logic [7:0] instr;
   logic [7:0] imm;
   logic       instr_two_byte;
   logic [7:0] instr_pc;

   typedef struct {
      logic [7:0] instr;
      logic [7:0] imm;
      logic       two;
      logic [7:0] pc;
   } exp_t;

   logic [7:0] mem [256];
   exp_t       sb_q [$];
   int         n_checks = 0;
   int         n_errors = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .imm            (imm),
      .instr_two_byte (instr_two_byte),
      .instr_pc       (instr_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference walk of the instruction stream starting at 'start'.
   task automatic push_stream(input logic [7:0] start, input int n);
      logic [7:0] pc;
      exp_t       e;
      pc = start;
      for (int i = 0; i < n; i++) begin
         e.instr = mem[pc];
         e.pc    = pc;
         if (mem[pc][7:4] == 4'd12) begin
            e.two = 1'b1;
            e.imm = mem[8'(pc + 8'd1)];
            pc    = pc + 8'd2;
         end else begin
            e.two = 1'b0;
            e.imm = 8'h00;
            pc    = pc + 8'd1;
         end
         sb_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rst && !redirect_valid && instr_valid && instr_ready && sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("sb_instr", instr, e.instr);
         check("sb_imm",   imm, e.imm);
         check("sb_two",   instr_two_byte, e.two);
         check("sb_pc",    instr_pc, e.pc);
      end
   end

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 5) & 8'hBF);
   endtask

   task automatic reset_hold();
      @(posedge clk); #1;
      rst = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic release_rst();
      #1 rst = 1'b1;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
      check(tag, sb_q.size(), 0);
   endtask

   initial begin
      int n_rd;
      int got_n;
      logic [7:0] rd_addrs [4];

      // Phase A: reset values, vector load, simple one-byte stream
      fill_mem();
      mem[8'h00] = 8'h10;
      mem[8'h10] = 8'h21; mem[8'h11] = 8'h32; mem[8'h12] = 8'h43; mem[8'h13] = 8'h54;
      reset_hold();
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_imm", imm, 0);
      check("rst_two", instr_two_byte, 0);
      check("rst_pc", instr_pc, 0);
      push_stream(8'h10, 4);
      release_rst();
      @(negedge clk);
      check("vec_rd_en", mem_rd_en, 1);
      check("vec_addr", mem_addr, 8'h00);
      @(negedge clk);
      check("vec_wait_rd_en", mem_rd_en, 0);
      @(negedge clk);
      check("run_rd_en", mem_rd_en, 1);
      check("run_addr", mem_addr, 8'h10);
      wait_drain("drain_a", 40);

      // Phase B: two-byte instruction
      fill_mem();
      mem[8'h00] = 8'h10;
      mem[8'h10] = 8'hC1; mem[8'h11] = 8'h5A; mem[8'h12] = 8'h23; mem[8'h13] = 8'h34;
      reset_hold();
      push_stream(8'h10, 3);
      release_rst();
      wait_drain("drain_b", 40);

      // Phase C: stall with queue full, then release
      fill_mem();
      mem[8'h00] = 8'h10;
      mem[8'h10] = 8'h21; mem[8'h11] = 8'hC2; mem[8'h12] = 8'h5B; mem[8'h13] = 8'h33;
      mem[8'h14] = 8'h44; mem[8'h15] = 8'hC7; mem[8'h16] = 8'h08; mem[8'h17] = 8'h55;
      instr_ready = 1'b0;
      reset_hold();
      release_rst();
      n_rd = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (mem_rd_en) n_rd++;
         if (i == 8) begin
            check("stall_mid_valid", instr_valid, 1);
            check("stall_mid_instr", instr, 8'h21);
            check("stall_mid_pc", instr_pc, 8'h10);
         end
      end
      check("stall_reads", n_rd, 5);
      check("stall_rd_idle", mem_rd_en, 0);
      check("stall_end_instr", instr, 8'h21);
      check("stall_end_pc", instr_pc, 8'h10);
      push_stream(8'h10, 6);
      @(posedge clk); #1 instr_ready = 1'b1;
      wait_drain("drain_c", 40);

      // Phase D: redirect while the read of 0x13 is returning
      fill_mem();
      mem[8'h00] = 8'h10;
      mem[8'h10] = 8'h21; mem[8'h11] = 8'h32; mem[8'h12] = 8'hC3; mem[8'h13] = 8'h44;
      mem[8'h14] = 8'h65;
      mem[8'h40] = 8'h51; mem[8'h41] = 8'hC2; mem[8'h42] = 8'h6E; mem[8'h43] = 8'h13;
      reset_hold();
      push_stream(8'h10, 2);
      push_stream(8'h40, 3);
      release_rst();
      got_n = 0;
      for (int i = 0; i < 30 && got_n == 0; i++) begin
         @(negedge clk);
         if (mem_rd_en && mem_addr == 8'h13) got_n = 1;
      end
      check("redir_seen_0x13", got_n, 1);
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc    = 8'h40;
      @(negedge clk);
      check("redir_no_issue", mem_rd_en, 0);
      check("redir_t0_valid", instr_valid, 0);
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      check("redir_issue_addr", mem_addr, 8'h40);
      check("redir_issue_en", mem_rd_en, 1);
      check("redir_t1_valid", instr_valid, 0);
      wait_drain("drain_d", 40);

      // Phase E: address wrap with a two-byte instruction straddling 0xFF/0x00
      mem[8'hFE] = 8'h21; mem[8'hFF] = 8'hC0; mem[8'h00] = 8'h77;
      mem[8'h01] = 8'h35; mem[8'h02] = 8'h46;
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFE;
      push_stream(8'hFE, 3);
      @(posedge clk); #1 redirect_valid = 1'b0;
      got_n = 0;
      for (int i = 0; i < 12 && got_n < 4; i++) begin
         @(negedge clk);
         if (mem_rd_en) begin
            rd_addrs[got_n] = mem_addr;
            got_n++;
         end
      end
      check("wrap_reads", got_n, 4);
      check("wrap_addr0", rd_addrs[0], 8'hFE);
      check("wrap_addr1", rd_addrs[1], 8'hFF);
      check("wrap_addr2", rd_addrs[2], 8'h00);
      check("wrap_addr3", rd_addrs[3], 8'h01);
      wait_drain("drain_e", 40);

      // Phase F: asynchronous reset while an instruction is presented
      got_n = 0;
      for (int i = 0; i < 20 && got_n == 0; i++) begin
         @(negedge clk);
         if (instr_valid) got_n = 1;
      end
      check("arst_pre_valid", instr_valid, 1);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", instr_valid, 0);
      check("arst_instr", instr, 0);
      check("arst_imm", imm, 0);
      check("arst_two", instr_two_byte, 0);
      check("arst_pc", instr_pc, 0);
      check("arst_rd_en", mem_rd_en, 0);
      check("arst_addr", mem_addr, 0);
      @(posedge clk);
      release_rst();
      @(negedge clk);
      check("arst_vec_rd_en", mem_rd_en, 1);
      check("arst_vec_addr", mem_addr, 8'h00);
      @(negedge clk);
      check("arst_vec_wait", mem_rd_en, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
